// File: rtl/demux4_stream.sv
// ---------------------------------------------------------------------------
// demux4_stream
//
// One-to-four stream router. Words tagged with a 2-bit destination select
// are accepted on a single valid/ready input channel, buffered in a small
// in-order FIFO, and delivered from the FIFO head to exactly one of four
// valid/ready output channels. Delivery is strictly in order: a stalled
// head blocks every later word, whatever its destination.
//
// Optional feature (compile-time macro DEMUX4_XFER_CNT_EN):
//   When defined, one CNT_W-bit wrapping counter per output port counts the
//   words delivered to that port. When undefined, no counter registers are
//   built and xfer_cnt is tied to zero. The port list is the same in both
//   builds.
//
// Parameters:
//   W      data width in bits
//   DEPTH  FIFO entries (power of two, >= 2)
//   CNT_W  width of each per-port transfer counter
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   producer has a word
//   in_ready   block accepts a word this cycle (registered, never depends
//              on out_ready)
//   in_data    word to route
//   in_sel     destination port 0..3
//   out_valid  one-hot; bit k set when the head word is destined for port k
//   out_ready  per-port consumer accept; only the selected port's bit counts
//   out_data   head word, shared by all ports (don't-care when empty)
//   occupancy  number of buffered words
//   xfer_cnt   per-port delivered-word counters, port k at [k*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module demux4_stream #(
    parameter int W     = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_data,
    input  logic [1:0]               in_sel,
    output logic [3:0]               out_valid,
    input  logic [3:0]               out_ready,
    output logic [W-1:0]             out_data,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [4*CNT_W-1:0]       xfer_cnt
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_W + 1;
    localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(DEPTH);

    typedef struct packed {
        logic [1:0]   sel;
        logic [W-1:0] data;
    } entry_t;

    entry_t              mem [DEPTH];
    entry_t              head;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_BITS-1:0] count;
    logic [CNT_BITS-1:0] count_nxt;
    logic                ready_q;
    logic                push;
    logic                pop;

    assign head = mem[rd_ptr];

    assign push = in_valid && ready_q;
    assign pop  = (count != '0) && out_ready[head.sel];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_BITS'(1);
            2'b01:   count_nxt = count - CNT_BITS'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers and count. DEPTH is a power of two, so the pointers wrap
    // modulo DEPTH by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
        end
    end

    // NOTE: in_ready is a flop loaded from the next count, so it equals
    // (count != DEPTH) in normal operation, is 0 throughout reset, and has
    // no combinational dependence on out_ready or in_valid.
    always_ff @(posedge clk) begin
        if (rst) ready_q <= 1'b0;
        else     ready_q <= (count_nxt != FULL);
    end

    // NOTE: the storage array carries no reset; an entry is only read after
    // it has been written, and the cleared count hides any stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{sel: in_sel, data: in_data};
    end

    assign in_ready  = ready_q;
    assign out_valid = (count != '0) ? (4'b0001 << head.sel) : 4'b0000;
    // Stale head contents when empty; consumers must qualify with out_valid.
    assign out_data  = head.data;
    assign occupancy = count;

`ifdef DEMUX4_XFER_CNT_EN
    logic [CNT_W-1:0] cnt_q [4];

    // Only the head's port can pop, so at most one counter moves per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
        end else if (pop) begin
            cnt_q[head.sel] <= cnt_q[head.sel] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign xfer_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`else
    assign xfer_cnt = '0;
`endif

endmodule
